serial_tx8: RTL and testbench
=============================

// Module: serial_tx8
// PURPOSE
//  Parallel-to-serial transmitter. Reads a byte presented by an 8-bit holding
//  register (SW-loaded, KEY-clocked) and shifts it out on one wire as an
//  async-serial frame: start bit, data bits LSB first, optional parity, stop bit.
//  It is the read/unload end of the parallel-load register path.
//  It drives a GPIO/LED pin or feeds a matching serial receiver in the same lab design.
// PARAMETERS
//  DATA_W        8   data bits per frame
//  CLKS_PER_BIT  4   CLK cycles per serial bit; legal range >=1
// PORTS
//  CLK     in   1       rising-edge clock; the only clock in the block
//  RESETN  in   1       asynchronous, active-low reset
//  D       in   DATA_W  parallel data; sampled only on an accepted load
//  LOAD    in   1       load request (valid)
//  READY   out  1       1 = idle and able to accept LOAD
//  BUSY    out  1       1 = frame in progress (always ~READY)
//  TXD     out  1       serial line; idles high
// BEHAVIOUR
//  Reset (RESETN=0): all outputs take their reset values immediately, regardless of CLK.
//   Reset values: TXD=1, READY=1, BUSY=0. State=IDLE. Shift reg, bit counter and
//   baud counter = 0. Reset aborts any frame in progress; no partial bits are resumed.
//  All outputs are registered and glitch-free.
//  Handshake: a load is accepted on a rising edge where LOAD=1 and READY=1.
//   D is captured into the shift register on that edge.
//   LOAD while READY=0 is ignored and is not queued.
//   Changes on D after capture have no effect on the frame in flight.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE:   TXD=1, READY=1. An accepted load moves to START.
//   START:  TXD=0 for CLKS_PER_BIT cycles.
//   DATA:   TXD=shreg[0] for CLKS_PER_BIT cycles per bit, then shift right.
//           Exactly DATA_W bits are sent; the bit counter runs 0..DATA_W-1.
//   PARITY: present only with the macro below.
//   STOP:   TXD=1 for CLKS_PER_BIT cycles, then go to IDLE.
//  Timing: if a load is accepted at edge k, TXD=0 and READY=0 from edge k.
//   The state returns to IDLE and READY=1 at edge k + F*CLKS_PER_BIT.
//   F = DATA_W+2, or DATA_W+3 with parity.
//   Back-to-back loads (LOAD held high) leave exactly one idle cycle (TXD=1,
//   READY=1) between frames.
//  Baud counter: width $clog2(CLKS_PER_BIT)+1. It counts 0..CLKS_PER_BIT-1 and
//   wraps to 0 at each bit boundary. CLKS_PER_BIT=1 must work: one bit per cycle.
//  RESETN asserted mid-frame: TXD returns high at once and READY=1.
//   The first edge after release behaves as IDLE.
// CONFIGURATION
//  SERIAL_TX_PARITY_EN defined:
//   - A PARITY state follows DATA, lasting CLKS_PER_BIT cycles.
//   - TXD = even parity: XOR of the DATA_W captured bits.
//   - The parity is computed from the captured byte at load time.
//  SERIAL_TX_PARITY_EN undefined:
//   - No PARITY state and no parity logic is synthesised.
//   - DATA goes directly to STOP.
// TESTING (CLKS_PER_BIT=4, DATA_W=8 unless noted)
//  1 Reset: RESETN=0 with CLK stopped -> TXD=1, READY=1, BUSY=0 with no clock edge.
//  2 Load D=8'hA5 -> TXD bits, 4 cycles each: 0,1,0,1,0,0,1,0,1,1.
//    READY returns high 40 cycles after accept.
//  3 Same frame with SERIAL_TX_PARITY_EN: parity bit 0 inserted before stop,
//    44 cycles total. D=8'h07 -> parity bit 1.
//  4 LOAD pulsed at cycles 5 and 20 of an 8'h3C frame -> both ignored;
//    only 8'h3C is sent; D changes mid-frame have no effect.
//  5 LOAD held high, D=8'h55 then 8'hAA -> two complete frames separated by
//    exactly 1 idle cycle.
//  6 RESETN pulsed low in bit 3 of an 8'hFF frame -> TXD=1 at once.
//    A new load of 8'h01 then produces a clean, complete frame.
//    Repeat with CLKS_PER_BIT=1.

Source files
------------

// File: rtl/serial_tx8.sv
`default_nettype none
// serial_tx8: async-serial frame transmitter (start, DATA_W bits LSB first, optional parity, stop).
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module serial_tx8 #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [DATA_W-1:0] D,
  input  logic              LOAD,
  output logic              READY,
  output logic              BUSY,
  output logic              TXD
);

  localparam int                BAUD_W      = $clog2(CLKS_PER_BIT) + 1;
  localparam int                BIT_W       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              r_state,  w_state_nxt;
  logic [BAUD_W-1:0]   r_baud,   w_baud_nxt;
  logic [BIT_W-1:0]    r_bit,    w_bit_nxt;
  logic [DATA_W-1:0]   r_shreg,  w_shreg_nxt;
  logic                r_txd,    w_txd_nxt;
  logic                r_ready,  w_ready_nxt;
  logic                r_busy;
  logic                w_baud_end;

`ifdef SERIAL_TX_PARITY_EN
  logic                r_par;

  // Parity comes from the byte as captured, so later D changes cannot affect it.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)                 r_par <= 1'b0;
    else if (LOAD && r_ready)    r_par <= ^D;
  end
`endif

  assign w_baud_end = (r_baud == C_BAUD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    case (r_state)
      S_IDLE: begin
        if (LOAD) begin
          w_state_nxt = S_START;
          w_shreg_nxt = D;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
        end else begin
          w_baud_nxt  = r_baud + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_shreg_nxt = r_shreg >> 1;
          if (r_bit == C_BIT_LAST) begin
            w_bit_nxt   = '0;
`ifdef SERIAL_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt   = r_bit + BIT_W'(1);
          end
        end else begin
          w_baud_nxt  = r_baud + BAUD_W'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) begin
          w_state_nxt = S_STOP;
          w_baud_nxt  = '0;
        end else begin
          w_baud_nxt  = r_baud + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_baud_end) begin
          w_state_nxt = S_IDLE;
          w_baud_nxt  = '0;
        end else begin
          w_baud_nxt  = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins change on the same edge as the state.
  always_comb begin
    w_txd_nxt   = 1'b1;
    w_ready_nxt = (w_state_nxt == S_IDLE);
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shreg_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: w_txd_nxt = r_par;
`endif
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_txd   <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_txd   <= w_txd_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= ~w_ready_nxt;
    end
  end

  assign TXD   = r_txd;
  assign READY = r_ready;
  assign BUSY  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx8.sv
`default_nettype none
// Scoreboard bench for serial_tx8: u_dut4 runs 4 clocks/bit, u_dut1 runs 1 clock/bit.
module tb_serial_tx8;

`ifdef SERIAL_TX_PARITY_EN
  localparam int NFRM = 11;
`else
  localparam int NFRM = 10;
`endif

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       rstn0 = 1'b1, rstn1 = 1'b1;
  logic       load0 = 1'b0, load1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  wire logic  txd0, rdy0, busy0, txd1, rdy1, busy1;

  always #5 clk = clk_en ? ~clk : clk;

  serial_tx8 #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut4 (
    .CLK(clk), .RESETN(rstn0), .D(d0), .LOAD(load0),
    .READY(rdy0), .BUSY(busy0), .TXD(txd0));

  serial_tx8 #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut1 (
    .CLK(clk), .RESETN(rstn1), .D(d1), .LOAD(load1),
    .READY(rdy1), .BUSY(busy1), .TXD(txd1));

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         cnt[2]        = '{-1, -1};
  logic [7:0] cur[2];
  bit         bad[2];
  int         bad_idx[2];
  logic       bad_t[2];
  logic       bad_e[2];
  int         start_cyc[2]  = '{0, 0};
  int         prev_start[2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Frame bit bi of byte v: start, 8 data bits LSB first, optional even parity, stop.
  function automatic logic exp_bit(input logic [7:0] v, input int bi);
    if (bi == 0) return 1'b0;
    if (bi <= 8) return v[bi-1];
    if (NFRM == 11 && bi == 9) return ^v;
    return 1'b1;
  endfunction

  // Monitor: detects a start bit, pops the expected byte and checks every sample of the frame.
  logic t, r, b, rs, e;
  int   cpb;
  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      t   = (ch == 0) ? txd0  : txd1;
      r   = (ch == 0) ? rdy0  : rdy1;
      b   = (ch == 0) ? busy0 : busy1;
      rs  = (ch == 0) ? rstn0 : rstn1;
      cpb = (ch == 0) ? 4 : 1;
      if (!rs) begin
        cnt[ch] = -1;
      end else begin
        if (cnt[ch] < 0 && t == 1'b0) begin
          prev_start[ch] = start_cyc[ch];
          start_cyc[ch]  = cyc;
          cnt[ch] = 0;
          bad[ch] = 1'b0;
          if ((ch == 0 ? q0.size() : q1.size()) == 0) begin
            chk(1'b0, $sformatf("unexpected_frame ch%0d", ch), 1, 0);
            cur[ch] = 8'h00;
          end else if (ch == 0) begin
            cur[ch] = q0.pop_front();
          end else begin
            cur[ch] = q1.pop_front();
          end
        end
        if (cnt[ch] >= 0 && cnt[ch] < NFRM * cpb) begin
          e = exp_bit(cur[ch], cnt[ch] / cpb);
          if (!bad[ch] && (t !== e || r !== 1'b0 || b !== 1'b1)) begin
            bad[ch] = 1'b1; bad_idx[ch] = cnt[ch]; bad_t[ch] = t; bad_e[ch] = e;
          end
          cnt[ch]++;
        end else if (cnt[ch] == NFRM * cpb) begin
          chk(!bad[ch], $sformatf("frame ch%0d data=%02h sample=%0d txd", ch, cur[ch], bad_idx[ch]),
              int'(bad_t[ch]), int'(bad_e[ch]));
          chk(r === 1'b1 && t === 1'b1 && b === 1'b0,
              $sformatf("ready_return ch%0d data=%02h {ready,txd,busy}", ch, cur[ch]),
              int'({r, t, b}), 3'b110);
          cnt[ch] = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int ch, input logic ld, input logic [7:0] dv);
    if (ch == 0) begin load0 = ld; d0 = dv; end
    else         begin load1 = ld; d1 = dv; end
  endtask

  function automatic logic rdy(input int ch);
    return (ch == 0) ? rdy0 : rdy1;
  endfunction

  task automatic push(input int ch, input logic [7:0] v);
    if (ch == 0) q0.push_back(v);
    else         q1.push_back(v);
  endtask

  task automatic wait_ready(input int ch);
    int n = 0;
    while (!rdy(ch) && n < 200) begin tick(); n++; end
    if (!rdy(ch)) chk(1'b0, $sformatf("ready_timeout ch%0d", ch), 0, 1);
  endtask

  task automatic send(input int ch, input logic [7:0] v);
    wait_ready(ch);
    set_in(ch, 1'b1, v);
    push(ch, v);
    tick();
    set_in(ch, 1'b0, v);
  endtask

  task automatic drain(input int ch);
    int n = 0;
    while (((ch == 0 ? q0.size() : q1.size()) != 0 || cnt[ch] >= 0) && n < 400) begin
      tick(); n++;
    end
    if (n >= 400) chk(1'b0, $sformatf("drain_timeout ch%0d", ch), n, 0);
    tick();
  endtask

  task automatic back_to_back(input int ch);
    int c = (ch == 0) ? 4 : 1;
    int n = 0;
    wait_ready(ch);
    set_in(ch, 1'b1, 8'h55);
    push(ch, 8'h55);
    tick();
    set_in(ch, 1'b1, 8'hAA);
    push(ch, 8'hAA);
    while (!rdy(ch) && n < 200) begin tick(); n++; end
    tick();
    set_in(ch, 1'b0, 8'hAA);
    drain(ch);
    chk(start_cyc[ch] - prev_start[ch] == NFRM * c + 1, $sformatf("b2b_spacing ch%0d", ch),
        start_cyc[ch] - prev_start[ch], NFRM * c + 1);
  endtask

  task automatic mid_reset(input int ch);
    int c = (ch == 0) ? 4 : 1;
    send(ch, 8'hFF);
    repeat (4 * c) tick();
    #1;
    if (ch == 0) rstn0 = 1'b0; else rstn1 = 1'b0;
    #1;
    chk(rdy(ch) === 1'b1, $sformatf("midreset_ready ch%0d", ch), int'(rdy(ch)), 1);
    chk(((ch == 0) ? txd0 : txd1) === 1'b1, $sformatf("midreset_txd ch%0d", ch),
        int'((ch == 0) ? txd0 : txd1), 1);
    chk(((ch == 0) ? busy0 : busy1) === 1'b0, $sformatf("midreset_busy ch%0d", ch),
        int'((ch == 0) ? busy0 : busy1), 0);
    tick();
    if (ch == 0) rstn0 = 1'b1; else rstn1 = 1'b1;
    tick();
    send(ch, 8'h01);
    drain(ch);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset with the clock stopped.
    #2;
    rstn0 = 1'b0;
    rstn1 = 1'b0;
    #1;
    chk(txd0 === 1'b1 && txd1 === 1'b1, "reset_txd", int'({txd0, txd1}), 2'b11);
    chk(rdy0 === 1'b1 && rdy1 === 1'b1, "reset_ready", int'({rdy0, rdy1}), 2'b11);
    chk(busy0 === 1'b0 && busy1 === 1'b0, "reset_busy", int'({busy0, busy1}), 2'b00);
    #5;
    rstn0 = 1'b1;
    rstn1 = 1'b1;
    clk_en = 1'b1;
    repeat (3) tick();

    for (int ch = 0; ch < 2; ch++) begin
      send(ch, 8'hA5); drain(ch);
      send(ch, 8'h07); drain(ch);
    end

    // Loads during a frame are ignored; D changes mid-frame are harmless.
    send(0, 8'h3C);
    repeat (4) tick();
    set_in(0, 1'b1, 8'hC3);
    tick();
    set_in(0, 1'b0, 8'h99);
    repeat (14) tick();
    set_in(0, 1'b1, 8'h81);
    tick();
    set_in(0, 1'b0, 8'h00);
    drain(0);

    back_to_back(0);
    back_to_back(1);
    mid_reset(0);
    mid_reset(1);

    chk(q0.size() == 0 && q1.size() == 0, "scoreboard_empty", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
